// File: rtl/ram_8k_8_dp_arb.sv
// Two-requester arbiter with lock/timeout in front of one port of an 8K x 8 dual-port RAM.
// Define RAM_ARB_ROUND_ROBIN_EN for round-robin tie-break; undefined gives fixed priority to requester 0.
module ram_8k_8_dp_arb #(
   parameter int unsigned ADDR_W   = 13,
   parameter int unsigned DATA_W   = 8,
   parameter int unsigned LOCK_TMO = 255
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              r0_req,
   input  logic              r0_lock,
   input  logic              r0_wen,
   input  logic [ADDR_W-1:0] r0_addr,
   input  logic [DATA_W-1:0] r0_wdata,
   output logic              r0_gnt,
   output logic              r0_rvalid,
   output logic [DATA_W-1:0] r0_rdata,
   input  logic              r1_req,
   input  logic              r1_lock,
   input  logic              r1_wen,
   input  logic [ADDR_W-1:0] r1_addr,
   input  logic [DATA_W-1:0] r1_wdata,
   output logic              r1_gnt,
   output logic              r1_rvalid,
   output logic [DATA_W-1:0] r1_rdata,
   output logic [ADDR_W-1:0] ram_addr,
   output logic [DATA_W-1:0] ram_din,
   output logic              ram_wen,
   input  logic [DATA_W-1:0] ram_dout,
   output logic              lock_err
);

`ifdef RAM_ARB_ROUND_ROBIN_EN
   localparam bit RoundRobin = 1'b1;
`else
   localparam bit RoundRobin = 1'b0;
`endif

   typedef enum logic [1:0] {StIdle, StOwn0, StOwn1} state_e;

   state_e      state_q;
   logic        prio_q;
   logic [15:0] lock_cnt_q;
   logic        rd_vld1_q, rd_id1_q, rd_vld2_q, rd_id2_q;

   logic              acc, sel, sel_lock, sel_wen;
   logic [ADDR_W-1:0] sel_addr;
   logic [DATA_W-1:0] sel_wdata;
   logic              own_id, own_req, own_lock, tmo;

   // Grants depend only on requests and registered state.
   always_comb begin
      r0_gnt = 1'b0;
      r1_gnt = 1'b0;
      if (rst_n) begin
         unique case (state_q)
            StIdle: begin
               if (r0_req && r1_req) begin
                  r0_gnt = ~prio_q;
                  r1_gnt = prio_q;
               end else begin
                  r0_gnt = r0_req;
                  r1_gnt = r1_req;
               end
            end
            StOwn0:  r0_gnt = r0_req;
            StOwn1:  r1_gnt = r1_req;
            default: ;
         endcase
      end
   end

   assign acc       = r0_gnt | r1_gnt;
   assign sel       = r1_gnt;
   assign sel_lock  = sel ? r1_lock  : r0_lock;
   assign sel_wen   = sel ? r1_wen   : r0_wen;
   assign sel_addr  = sel ? r1_addr  : r0_addr;
   assign sel_wdata = sel ? r1_wdata : r0_wdata;

   assign own_id   = (state_q == StOwn1);
   assign own_req  = own_id ? r1_req  : r0_req;
   assign own_lock = own_id ? r1_lock : r0_lock;
   assign tmo      = (state_q != StIdle) && (lock_cnt_q == 16'(LOCK_TMO - 1));

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q    <= StIdle;
         prio_q     <= 1'b0;
         lock_cnt_q <= '0;
         rd_vld1_q  <= 1'b0;
         rd_id1_q   <= 1'b0;
         rd_vld2_q  <= 1'b0;
         rd_id2_q   <= 1'b0;
         ram_addr   <= '0;
         ram_din    <= '0;
         ram_wen    <= 1'b0;
         r0_rvalid  <= 1'b0;
         r1_rvalid  <= 1'b0;
         r0_rdata   <= '0;
         r1_rdata   <= '0;
         lock_err   <= 1'b0;
      end else begin
         ram_wen  <= acc && sel_wen;
         lock_err <= 1'b0;
         if (acc) begin
            ram_addr <= sel_addr;
            ram_din  <= sel_wdata;
            prio_q   <= RoundRobin ? ~sel : 1'b0;
         end

         // Requester-ID tag follows each read through the two-cycle RAM latency.
         rd_vld1_q <= acc && !sel_wen;
         rd_id1_q  <= sel;
         rd_vld2_q <= rd_vld1_q;
         rd_id2_q  <= rd_id1_q;
         r0_rvalid <= rd_vld2_q && !rd_id2_q;
         r1_rvalid <= rd_vld2_q && rd_id2_q;
         if (rd_vld2_q && !rd_id2_q) r0_rdata <= ram_dout;
         if (rd_vld2_q && rd_id2_q)  r1_rdata <= ram_dout;

         case (state_q)
            StIdle: begin
               lock_cnt_q <= '0;
               if (acc && sel_lock) state_q <= sel ? StOwn1 : StOwn0;
            end
            default: begin
               if (tmo) begin
                  // Timeout overrides any lock request and hands the tie to the other side.
                  state_q    <= StIdle;
                  lock_cnt_q <= '0;
                  lock_err   <= 1'b1;
                  prio_q     <= ~own_id;
               end else if (acc ? !sel_lock : (!own_req && !own_lock)) begin
                  state_q    <= StIdle;
                  lock_cnt_q <= '0;
               end else begin
                  lock_cnt_q <= lock_cnt_q + 16'd1;
               end
            end
         endcase
      end
   end

endmodule

// File: doc/ram_8k_8_dp_arb.md
RAM_8K_8_DP_ARB -- requirements
Module: ram_8k_8_dp_arb

Interface
REQ-001 Parameters SHALL be: ADDR_W, 13, RAM word address width; DATA_W, 8, data width; LOCK_TMO, 255, maximum cycles one requester may hold a lock.
REQ-002 The block SHALL have one clock, CLK; reset RST_N is synchronous and active-low.
REQ-003 CLK  in  1  rising-edge clock for all state and for the attached RAM port.
REQ-004 RST_N  in  1  synchronous active-low reset.
REQ-005 Rn_REQ  in  1  access request from requester n (n = 0, 1).
REQ-006 Rn_LOCK  in  1  hold exclusive ownership after this access.
REQ-007 Rn_WEN  in  1  1 = write, 0 = read.
REQ-008 Rn_ADDR  in  ADDR_W  word address.
REQ-009 Rn_WDATA  in  DATA_W  write data.
REQ-010 Rn_GNT  out  1  combinational grant; access accepted at an edge where Rn_REQ and Rn_GNT are both 1.
REQ-011 Rn_RVALID  out  1  one-cycle read-data-valid pulse.
REQ-012 Rn_RDATA  out  DATA_W  read data, valid while Rn_RVALID = 1.
REQ-013 RAM_ADDR  out  ADDR_W; RAM_DIN  out  DATA_W; RAM_WEN  out  1 -- registered drive to one port of the 8K x 8 dual-port RAM.
REQ-014 RAM_DOUT  in  DATA_W  RAM flow-through read data, valid in the cycle after the RAM samples its address.
REQ-015 LOCK_ERR  out  1  one-cycle pulse on lock timeout.

Function
REQ-016 At most one Rn_GNT SHALL be 1 in any cycle; a grant SHALL be given only to an asserting requester.
REQ-017 Arbiter states SHALL be IDLE, OWN0, OWN1; in OWNn only requester n may be granted.
REQ-018 In IDLE with both requests pending, the winner SHALL be set by REQ-041; a single pending request SHALL be granted immediately.
REQ-019 An accepted access with Rn_LOCK = 1 SHALL move to OWNn; an accepted access with Rn_LOCK = 0, or a cycle with Rn_REQ = 0 and Rn_LOCK = 0, SHALL return OWNn to IDLE.
REQ-020 An access accepted at edge E SHALL drive RAM_ADDR/RAM_DIN/RAM_WEN during cycle E..E+1; RAM_WEN = 0 in cycles with no accepted access, RAM_ADDR/RAM_DIN hold.
REQ-021 For a read accepted at edge E, Rn_RDATA SHALL be registered from RAM_DOUT at E+2 and Rn_RVALID SHALL be 1 for exactly one cycle from E+2; writes produce no RVALID.
REQ-022 Throughput SHALL be one access per cycle; back-to-back reads SHALL return in order with a requester-ID tag pipeline routing each RVALID.
REQ-023 A read accepted at E+1 after a write to the same address at E SHALL return the new data.
REQ-024 A 16-bit lock counter SHALL clear on entry to OWNn and increment each cycle in OWNn; on reaching LOCK_TMO the state SHALL be forced to IDLE, LOCK_ERR pulsed for one cycle, and the other requester given priority for the next arbitration.
REQ-025 Rn_GNT SHALL be combinational from Rn_REQ and registered state only, never from RAM_DOUT.

Reset
REQ-026 RST_N = 0 at an edge SHALL set state IDLE, priority pointer to requester 0, lock counter 0, RAM_ADDR 0, RAM_DIN 0, RAM_WEN 0, Rn_RVALID 0, Rn_RDATA 0, LOCK_ERR 0.
REQ-027 While RST_N = 0, both Rn_GNT SHALL be 0.
REQ-028 Reads in flight when reset is applied SHALL be discarded; no RVALID SHALL follow reset release for them.

Configuration
REQ-029 Macro RAM_ARB_ROUND_ROBIN_EN SHALL select the IDLE tie-break policy.
REQ-041 Defined: round-robin -- the requester not granted most recently wins a tie, pointer updated on each accepted access; undefined: fixed priority -- requester 0 always wins a tie.

Verification
REQ-030 R0 write addr 0x0010 data 0xA5, then R0 read 0x0010 -> RAM_WEN pulse next cycle; R0_RVALID two edges after read acceptance with R0_RDATA = 0xA5.
REQ-031 R0 and R1 both read continuously for 8 cycles -> with RAM_ARB_ROUND_ROBIN_EN grants alternate 0,1,0,1; without it R0 granted all 8 cycles.
REQ-032 R1 read 0x1FFF with R1_LOCK = 1, then R0 requests for 3 cycles while R1 reads 0x0000, 0x0001 with LOCK = 1, last with LOCK = 0 -> R0_GNT = 0 until cycle after R1 unlocks.
REQ-033 LOCK_TMO = 4, R1 holds LOCK = 1 with continuous requests, R0 pending -> LOCK_ERR pulses once after 4 OWN1 cycles, next grant to R0.
REQ-034 Issue two reads, assert RST_N = 0 one cycle after acceptance -> no Rn_RVALID after reset; all outputs at REQ-026 values.
